// File: rtl/relay_ctrl_pkg.sv
// Shared types for the relay run controller: FSM state encoding and default record width.
// No logic; imported by the controller and its testbench-facing top.
package relay_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // One output_struct record is 12 bytes.
   localparam int REC_W_DEFAULT = 96;

endpackage

// File: rtl/relay_trace_fifo.sv
// First-word-fall-through FIFO for trace records; head visible 1 cycle after push.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module relay_trace_fifo #(
   parameter int W     = 96,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/relay_run_controller.sv
// Loads a program image, clock-enables the relay computer until Halt (or timeout with RELAY_RUN_TIMEOUT_EN), drains trace.
// Memory write 1 cycle after accept; a full trace FIFO stalls the computer via comp_run; out_ready backpressures the FIFO.
module relay_run_controller
   import relay_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 15,
   parameter int REC_W       = REC_W_DEFAULT,
   parameter int TRACE_DEPTH = 16,
   parameter int MAX_CYCLES  = 65535
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              comp_run,
   input  logic              comp_halt,
   input  logic              rec_valid,
   input  logic [REC_W-1:0]  rec_data,
   output logic              out_valid,
   output logic [REC_W-1:0]  out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              done,
   output logic              load_ovf,
   output logic              trace_ovf,
   output logic              timeout
);

   localparam int CW = $clog2(TRACE_DEPTH) + 1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   addr;
   logic              start_go;
   logic              accept;
   logic              addr_ovf;
   logic              timeout_hit;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [REC_W-1:0]  fifo_dout;
   logic [CW-1:0]     fifo_count;

   assign start_go  = start && ((state == IDLE) || (state == DONE));
   assign accept    = in_valid && in_ready;
   // The extra MSB marks that the last address has been written; addr saturates there.
   assign addr_ovf  = addr[ADDR_W];
   assign fifo_push = (state == RUN) && rec_valid;
   assign fifo_pop  = out_valid && out_ready;
   assign out_data  = out_valid ? fifo_dout : '0;
   assign out_last  = out_valid && (state == DRAIN) && (fifo_count == CW'(1));

   relay_trace_fifo #(
      .W     (REC_W),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .din   (rec_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = LOAD;
         LOAD:       if (accept && in_last) state_nxt = RUN;
         RUN:        if (comp_halt || timeout_hit) state_nxt = DRAIN;
         DRAIN:      if (fifo_empty || ((fifo_count == CW'(1)) && fifo_pop)) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      comp_run  = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state)
         LOAD: in_ready = 1'b1;
         RUN: begin
            comp_run  = !fifo_full && !comp_halt;
            out_valid = !fifo_empty;
         end
         DRAIN: out_valid = !fifo_empty;
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         load_ovf  <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (start_go) begin
            addr     <= '0;
            load_ovf <= 1'b0;
         end else if (accept) begin
            if (!addr_ovf) begin
               mem_we    <= 1'b1;
               mem_addr  <= addr[ADDR_W-1:0];
               mem_wdata <= in_data;
               addr      <= addr + (ADDR_W+1)'(1);
            end else begin
               load_ovf <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                   trace_ovf <= 1'b0;
      else if (start_go)                           trace_ovf <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop) trace_ovf <= 1'b1;
   end

`ifdef RELAY_RUN_TIMEOUT_EN
   logic [31:0] cyc_cnt;

   // Fires on the MAX_CYCLES-th enabled cycle; the DRAIN transition removes comp_run next cycle.
   assign timeout_hit = comp_run && (cyc_cnt == 32'(MAX_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cyc_cnt <= '0;
         timeout <= 1'b0;
      end else if (start_go) begin
         cyc_cnt <= '0;
         timeout <= 1'b0;
      end else if (comp_run) begin
         cyc_cnt <= cyc_cnt + 32'd1;
         if (timeout_hit) timeout <= 1'b1;
      end
   end
`else
   logic unused_max_cycles;

   assign timeout_hit       = 1'b0;
   assign timeout           = 1'b0;
   assign unused_max_cycles = (MAX_CYCLES != 0);
`endif

endmodule

// File: tb/tb_relay_run_controller.sv
// Directed bench for relay_run_controller: table-driven load/trace run plus hand sequences for
// backpressure, load overflow with empty halt, timeout (or its absence) and reset mid-run.
module tb_relay_run_controller;

   localparam int AW = 3;
   localparam int RW = 96;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [RW-1:0] RA = 96'h1111_2222_3333_4444_5555_000A;
   localparam logic [RW-1:0] RB = 96'h6666_7777_8888_9999_AAAA_000B;
   localparam logic [RW-1:0] RC = 96'hCCCC_DDDD_EEEE_FFFF_0123_000C;
   localparam logic [RW-1:0] RE = 96'h0E0E_0E0E_0E0E_0E0E_0E0E_000E;
   localparam logic [RW-1:0] Z  = '0;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_last;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          comp_run;
   logic          comp_halt;
   logic          rec_valid;
   logic [RW-1:0] rec_data;
   logic          out_valid;
   logic [RW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   logic          done;
   logic          load_ovf;
   logic          trace_ovf;
   logic          timeout;

   int vec_cnt = 0;
   int err_cnt = 0;

   relay_run_controller #(
      .ADDR_W      (AW),
      .REC_W       (RW),
      .TRACE_DEPTH (16),
      .MAX_CYCLES  (10)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .comp_run  (comp_run),
      .comp_halt (comp_halt),
      .rec_valid (rec_valid),
      .rec_data  (rec_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .done      (done),
      .load_ovf  (load_ovf),
      .trace_ovf (trace_ovf),
      .timeout   (timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          start, in_valid;
      logic [7:0]    in_data;
      logic          in_last, comp_halt, rec_valid;
      logic [RW-1:0] rec;
      logic          out_ready;
      logic          x_in_ready, x_mem_we;
      logic [AW-1:0] x_mem_addr;
      logic [7:0]    x_mem_wdata;
      logic          x_comp_run, x_out_valid;
      logic [RW-1:0] x_out_data;
      logic          x_out_last, x_done;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_one(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [RW-1:0] rec_of(input int k);
      return {64'hFEED_0000_0000_0000, 32'(k)};
   endfunction

   function automatic logic [115:0] all_outs();
      return {in_ready, mem_we, mem_addr, mem_wdata, comp_run, out_valid, out_data,
              out_last, done, load_ovf, trace_ovf, timeout};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, rcv, runs, wr_cnt, exp_runs;
      logic stalled, exp_to;

      //          st in  dat   lst hlt rv  rec out_rdy | ird we  addr   wdat   run ov  odata lst done
      tbl[0]  = '{H, L, 8'h00, L,  L,  L,  Z,  L,        L,  L,  3'd0, 8'h00, L,  L,  Z,  L,  L};
      tbl[1]  = '{L, H, 8'h11, L,  L,  L,  Z,  L,        H,  L,  3'd0, 8'h00, L,  L,  Z,  L,  L};
      tbl[2]  = '{L, H, 8'h12, L,  L,  L,  Z,  L,        H,  H,  3'd0, 8'h11, L,  L,  Z,  L,  L};
      tbl[3]  = '{L, H, 8'h13, L,  L,  L,  Z,  L,        H,  H,  3'd1, 8'h12, L,  L,  Z,  L,  L};
      tbl[4]  = '{L, H, 8'h14, L,  L,  L,  Z,  L,        H,  H,  3'd2, 8'h13, L,  L,  Z,  L,  L};
      tbl[5]  = '{L, H, 8'h15, H,  L,  L,  Z,  L,        H,  H,  3'd3, 8'h14, L,  L,  Z,  L,  L};
      tbl[6]  = '{L, L, 8'h00, L,  L,  H,  RA, H,        L,  H,  3'd4, 8'h15, H,  L,  Z,  L,  L};
      tbl[7]  = '{L, L, 8'h00, L,  L,  H,  RB, H,        L,  L,  3'd0, 8'h00, H,  H,  RA, L,  L};
      tbl[8]  = '{L, L, 8'h00, L,  L,  H,  RC, H,        L,  L,  3'd0, 8'h00, H,  H,  RB, L,  L};
      tbl[9]  = '{L, L, 8'h00, L,  H,  L,  Z,  L,        L,  L,  3'd0, 8'h00, L,  H,  RC, L,  L};
      tbl[10] = '{L, L, 8'h00, L,  H,  L,  Z,  H,        L,  L,  3'd0, 8'h00, L,  H,  RC, H,  L};
      tbl[11] = '{L, L, 8'h00, L,  L,  L,  Z,  H,        L,  L,  3'd0, 8'h00, L,  L,  Z,  L,  H};

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      comp_halt = 1'b0; rec_valid = 1'b0; rec_data = '0; out_ready = 1'b0;
      #1 reset = 1'b1;
      #2 check("reset_outputs", 128'(all_outs()), '0);
      tick();
      tick();
      reset = 1'b0;

      // Load 0x11..0x15, then three trace records A,B,C.
      for (int i = 0; i < 12; i++) begin
         start = tbl[i].start; in_valid = tbl[i].in_valid; in_data = tbl[i].in_data;
         in_last = tbl[i].in_last; comp_halt = tbl[i].comp_halt; rec_valid = tbl[i].rec_valid;
         rec_data = tbl[i].rec; out_ready = tbl[i].out_ready;
         #1;
         check($sformatf("v%0d ctrl", i),
               128'({in_ready, mem_we, comp_run, out_valid, out_last, done}),
               128'({tbl[i].x_in_ready, tbl[i].x_mem_we, tbl[i].x_comp_run,
                     tbl[i].x_out_valid, tbl[i].x_out_last, tbl[i].x_done}));
         if (tbl[i].x_mem_we)
            check($sformatf("v%0d mem", i), 128'({mem_addr, mem_wdata}),
                  128'({tbl[i].x_mem_addr, tbl[i].x_mem_wdata}));
         if (tbl[i].x_out_valid)
            check($sformatf("v%0d out_data", i), 128'(out_data), 128'(tbl[i].x_out_data));
         @(posedge clock);
         #1;
      end
      check("table_flags", 128'({load_ovf, trace_ovf, timeout}), '0);
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; comp_halt = 1'b0; rec_valid = 1'b0;

      // Backpressure: out_ready low stalls the computer after exactly 16 records.
      kick();
      load_one(8'h5A);
      out_ready = 1'b0;
      sent = 0;
      stalled = 1'b0;
      for (int c = 0; c < 40 && !stalled; c++) begin
         if (comp_run) begin
            rec_valid = 1'b1; rec_data = rec_of(sent); sent++;
            tick();
         end else begin
            rec_valid = 1'b0; stalled = 1'b1;
         end
      end
      check("bp_records_before_stall", 128'(sent), 128'(16));
      for (int c = 0; c < 3; c++) begin
         check("bp_still_stalled", 128'({comp_run, out_valid}), 128'(2'b01));
         tick();
      end
      out_ready = 1'b1;
      rcv = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         comp_halt = (sent >= 24);
         #1;
         if (comp_run) begin
            rec_valid = 1'b1; rec_data = rec_of(sent); sent++;
         end else begin
            rec_valid = 1'b0;
         end
         if (out_valid && out_ready) begin
            check("bp_order", 128'(out_data), 128'(rec_of(rcv)));
            check("bp_last", 128'(out_last), 128'(rcv == 23));
            rcv++;
         end
         tick();
      end
      check("bp_received", 128'(rcv), 128'(24));
      check("bp_done_no_ovf", 128'({done, trace_ovf}), 128'(2'b10));
      comp_halt = 1'b0; rec_valid = 1'b0;

      // Load overflow: 10 bytes into 8 locations, then halt at RUN entry.
      kick();
      wr_cnt = 0;
      for (int b = 0; b < 10; b++) begin
         in_valid = 1'b1; in_data = 8'h40 + 8'(b); in_last = (b == 9);
         #1;
         if (mem_we) begin
            check("ovf_write", 128'({mem_addr, mem_wdata}),
                  128'({3'(wr_cnt), 8'h40 + 8'(wr_cnt)}));
            wr_cnt++;
         end
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0; comp_halt = 1'b1;
      #1;
      check("ovf_writes", 128'(wr_cnt), 128'(8));
      check("ovf_run_entry", 128'({mem_we, load_ovf, comp_run, out_valid, done}), 128'(5'b01000));
      tick();
      check("ovf_drain", 128'({out_valid, out_last, done}), '0);
      tick();
      check("ovf_done", 128'({out_valid, done}), 128'(2'b01));
      comp_halt = 1'b0;

      // Timeout: with the feature, exactly MAX_CYCLES enabled cycles; without it, halt ends the run.
`ifdef RELAY_RUN_TIMEOUT_EN
      exp_runs = 10; exp_to = 1'b1;
`else
      exp_runs = 12; exp_to = 1'b0;
`endif
      kick();
      check("to_flags_cleared", 128'({load_ovf, trace_ovf, timeout}), '0);
      load_one(8'h77);
      out_ready = 1'b1;
      runs = 0; rcv = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         comp_halt = (runs >= 12);
         #1;
         if (comp_run) begin
            rec_valid = 1'b1; rec_data = rec_of(100 + runs); runs++;
         end else begin
            rec_valid = 1'b0;
         end
         if (out_valid && out_ready) rcv++;
         tick();
      end
      check("to_run_cycles", 128'(runs), 128'(exp_runs));
      check("to_received", 128'(rcv), 128'(exp_runs));
      check("to_flag_done", 128'({timeout, done}), 128'({exp_to, 1'b1}));
      comp_halt = 1'b0; rec_valid = 1'b0;

      // Reset mid-run with 4 buffered records, then a clean run.
      kick();
      load_one(8'h01);
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         rec_valid = 1'b1; rec_data = rec_of(200 + c);
         tick();
      end
      rec_valid = 1'b0;
      check("rst_buffered", 128'({comp_run, out_valid}), 128'(2'b11));
      #2 reset = 1'b1;
      #1 check("rst_outputs", 128'(all_outs()), '0);
      tick();
      reset = 1'b0;
      kick();
      in_valid = 1'b1; in_data = 8'h21; tick();
      load_one(8'h22);
      rec_valid = 1'b1; rec_data = RE;
      tick();
      rec_valid = 1'b0; comp_halt = 1'b1;
      #1 check("rst_head", 128'({out_valid, out_data}), 128'({1'b1, RE}));
      tick();
      out_ready = 1'b1;
      rcv = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         if (out_valid && out_ready) begin
            check("rst_new_record", 128'({out_data, out_last}), 128'({RE, 1'b1}));
            rcv++;
         end
         tick();
      end
      check("rst_count", 128'(rcv), 128'(1));
      check("rst_done", 128'(done), 128'(1));
      comp_halt = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/relay_run_controller.md
Name: relay_run_controller

Overview:
- Sequences one program run of the relay computer in the emulation top.
- Streams a program image from the byte input pipe into computer memory, then enables the computer's clock until Halt or timeout.
- Buffers per-cycle output records in a trace FIFO and drains them to the output pipe, marking the last record.
- Replaces the ad-hoc gated-clock and loop logic with one synthesizable FSM on a single free-running clock.

Parameters:
ADDR_W, 15, program memory address width; capacity 2**ADDR_W bytes
REC_W, 96, width of one output record (12-byte output_struct)
TRACE_DEPTH, 16, trace FIFO entries (power of 2, >=2)
MAX_CYCLES, 65535, enabled-cycle limit before forced stop (TIMEOUT_EN only)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a run from IDLE or DONE
in_valid  in  1  input byte valid
in_data  in  8  program byte
in_last  in  1  marks final program byte
in_ready  out  1  controller accepts input byte
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  8  memory write data
comp_run  out  1  clock enable for the relay computer
comp_halt  in  1  computer has executed HALT (level)
rec_valid  in  1  computer output record valid (one per enabled cycle)
rec_data  in  REC_W  computer output record
out_valid  out  1  output record valid
out_data  out  REC_W  output record
out_last  out  1  final record of run
out_ready  in  1  output pipe accepts record
done  out  1  run finished (level, until next start)
load_ovf  out  1  sticky: more than 2**ADDR_W bytes received
trace_ovf  out  1  sticky: record dropped on full FIFO
timeout  out  1  sticky: MAX_CYCLES reached

Behaviour:
- Reset: state IDLE, FIFO empty, address 0, all counters 0.
- Reset output values: every output 0.
- States:
  - IDLE -> LOAD on start.
  - LOAD -> RUN the cycle after the in_last beat is accepted.
  - RUN -> DRAIN when comp_halt=1 or timeout fires.
  - DRAIN -> DONE when the FIFO is empty and the final handshake completes.
  - DONE -> LOAD on start.
  - start is ignored in LOAD, RUN and DRAIN.
- start from DONE clears done, load_ovf, trace_ovf, timeout, the address and the cycle counter.
- LOAD:
  - in_ready=1.
  - An accepted beat (in_valid&in_ready) registers mem_we=1, mem_addr=addr, mem_wdata=in_data on the next cycle, then addr increments.
  - Write latency is exactly 1 cycle.
  - Bytes after address 2**ADDR_W-1 are accepted but not written; load_ovf is set. There is no wrap-around.
  - in_ready=0 in all other states.
- RUN:
  - comp_run = !fifo_full && !comp_halt. A full FIFO stalls the computer rather than losing records.
  - rec_valid pushes rec_data.
  - rec_valid while full drops the record and sets trace_ovf. This is a protocol error, since a stalled computer must not emit records.
- FIFO pop: the head is presented on out_valid/out_data in RUN and DRAIN, popping on out_valid&out_ready.
- Simultaneous push and pop is allowed when full or empty (first-word-fall-through, 1-cycle push-to-out_valid).
- out_last=1 only with out_valid in DRAIN when count==1.
- Halt with empty FIFO: no record is emitted, no out_last, and DRAIN -> DONE next cycle.
- DONE: done=1, comp_run=0.
- Reset mid-run immediately returns to IDLE and drops all FIFO contents.

Optional Feature:
- RELAY_RUN_TIMEOUT_EN defined:
  - A 32-bit counter counts comp_run=1 cycles.
  - On reaching MAX_CYCLES: timeout=1, comp_run=0 next cycle, go to DRAIN.
- Undefined: no counter, timeout tied 0, RUN exits only on comp_halt.

Decomposition:
- Package relay_ctrl_pkg: state enum (IDLE, LOAD, RUN, DRAIN, DONE) and REC_W default constant.
- Sub-module relay_trace_fifo(clock, reset, push, din, pop, dout, full, empty, count): the parameterized FWFT FIFO.
- FSM, load addressing and flags stay in relay_run_controller.

Test Plan:
- Load test: start, 5 bytes 0x11..0x15 with in_last on 5th -> mem writes addr 0..4 with those data, 1 cycle after each accept; RUN entered cycle after last accept.
- Trace order: comp_halt after 3 records A,B,C, out_ready=1 -> out_data A,B,C in order; out_last only on C; done=1.
- Backpressure: TRACE_DEPTH=16, out_ready=0 during RUN -> comp_run drops after 16 records; trace_ovf=0; releasing out_ready resumes the run with no loss.
- Timeout: RELAY_RUN_TIMEOUT_EN, MAX_CYCLES=10, comp_halt never asserted -> exactly 10 comp_run cycles; timeout=1; DRAIN then DONE.
- Load overflow and empty halt: ADDR_W=2, 6 bytes -> 4 writes, load_ovf=1; comp_halt at RUN entry -> no out_valid, done after 1 cycle.
- Reset in RUN with 4 records buffered -> all outputs 0 immediately; a following start with a new load completes normally with no stale records.
